// File: rtl/router_ahb_master.sv
// AHB-Lite single-transfer initiator for the router CSR slave port: one request -> address phase -> data phase -> response.
// Optional wait-state watchdog enabled by defining ROUTER_AHB_MST_TIMEOUT_EN.
module router_ahb_master #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [AWIDTH-1:0] i_req_addr,
    input  logic [DWIDTH-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DWIDTH-1:0] o_rsp_rdata,
    output logic              o_rsp_error,
    output logic              o_rsp_timeout,
    output logic              o_hsel,
    output logic [AWIDTH-1:0] o_haddr,
    output logic              o_hwrite,
    output logic [1:0]        o_htrans,
    output logic [2:0]        o_hsize,
    output logic [2:0]        o_hburst,
    output logic [DWIDTH-1:0] o_hwdata,
    input  logic              i_hready,
    input  logic [DWIDTH-1:0] i_hrdata,
    input  logic [1:0]        i_hresp
);

    if (DWIDTH != 32 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
        $error("router_ahb_master: DWIDTH must be 32 and TIMEOUT within 2..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]        HRESP_ERROR   = 2'b01;
    localparam logic [AWIDTH-1:0] ADDR_MASK     = ~AWIDTH'(3);

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                hsel_q, hsel_d;
    logic [AWIDTH-1:0]   haddr_q, haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [1:0]          htrans_q, htrans_d;
    logic [DWIDTH-1:0]   hwdata_q, hwdata_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_error_q, rsp_error_d;
    logic                accept;
    logic                done;
    logic                abort;

    assign accept = (state_q == ST_IDLE) && i_req_valid && req_ready_q;
    assign done   = (state_q == ST_DATA) && i_hready;

`ifdef ROUTER_AHB_MST_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q, cnt_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        waiting;

    assign waiting = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !i_hready;
    assign abort   = waiting && ((cnt_q + 16'd1) == TO_LIMIT);

    always_comb begin
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
        if (accept) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (abort) begin
            rsp_timeout_d = 1'b1;
        end else if (done || state_q == ST_RESP) begin
            rsp_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign o_rsp_timeout = rsp_timeout_q;
`else
    assign abort         = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_ADDR;
            ST_ADDR: begin
                if (i_hready)   state_d = ST_DATA;
                else if (abort) state_d = ST_RESP;
            end
            ST_DATA: begin
                if (i_hready)   state_d = ST_RESP;
                else if (abort) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every bus/response signal leaves a flop.
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        hsel_d      = (state_d == ST_ADDR);
        htrans_d    = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        wdata_d     = wdata_q;
        if (accept) begin
            haddr_d  = i_req_addr & ADDR_MASK;
            hwrite_d = i_req_write;
            wdata_d  = i_req_wdata;
        end
        hwdata_d    = ((state_d == ST_DATA) && hwrite_q) ? wdata_q : '0;
        rsp_valid_d = (state_d == ST_RESP);
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        if (done) begin
            rsp_rdata_d = hwrite_q ? '0 : i_hrdata;
            rsp_error_d = (i_hresp == HRESP_ERROR);
        end else if (abort) begin
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
        end else if (state_q == ST_RESP) begin
            rsp_rdata_d = '0;
            rsp_error_d = 1'b0;
        end
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            req_ready_q <= 1'b0;
            hsel_q      <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            req_ready_q <= req_ready_d;
            hsel_q      <= hsel_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_hsel      = hsel_q;
    assign o_haddr     = haddr_q;
    assign o_hwrite    = hwrite_q;
    assign o_htrans    = htrans_q;
    assign o_hsize     = 3'b010;
    assign o_hburst    = 3'b000;
    assign o_hwdata    = hwdata_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_error = rsp_error_q;

endmodule
